regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: ALU/execute results and load-unit (LSU) results.
- Arbitrates with a round-robin policy and drives one registered write port (enable/pointer/data) into the register file.
- Maintains a pending-write scoreboard of in-flight destination registers so issue logic can detect read-after-write hazards.

Parameters:
- XLEN, 32, data width of a register and of all write data.
- NREG, 32, number of architectural registers; pointer width is log2(NREG).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request granted this cycle (combinational).
- alu_rd  input  log2(NREG)  ALU destination register.
- alu_data  input  XLEN  ALU result.
- lsu_valid  input  1  load writeback request.
- lsu_ready  output  1  LSU request granted this cycle (combinational).
- lsu_rd  input  log2(NREG)  load destination register.
- lsu_data  input  XLEN  load result.
- issue_valid  input  1  instruction issued with a destination; marks issue_rd pending.
- issue_rd  input  log2(NREG)  destination of issued instruction.
- wb_en  output  1  register-file write enable (registered).
- wb_ptr  output  log2(NREG)  register-file write pointer (registered).
- wb_data  output  XLEN  register-file write data (registered).
- pending  output  NREG  bit i = write to register i in flight (registered).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values:
  - wb_en=0, wb_ptr=0, wb_data=0.
  - pending=0.
  - Internal last_grant=LSU, so the first contention goes to the ALU.
  - alu_ready and lsu_ready are 0 while reset is high.
- Handshake: a transfer completes on a cycle where valid && ready.
  - Requesters hold valid, rd and data stable until ready.
  - ready never depends on data or rd.
- Arbitration, each cycle when not in reset:
  - Only one valid: grant it.
  - Both valid: grant the source not equal to last_grant; the other's ready=0.
  - Neither valid: no grant.
  - last_grant updates to the granted source on every grant, including uncontended ones.
  - At most one ready is high per cycle.
- Write port, latency 1:
  - On the edge after a grant: wb_en=1, wb_ptr=granted rd, wb_data=granted data.
  - Cycles without a grant: wb_en=0; wb_ptr/wb_data hold their last values.
  - Back-to-back grants produce back-to-back writes; sustained throughput is 1 write per cycle.
- Register 0:
  - A grant with rd=0 completes the handshake but produces wb_en=0 next cycle.
  - pending[0] is always 0, and issue_rd=0 sets nothing.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 sets pending[issue_rd] at the next edge.
  - Clear: a grant with rd=r clears pending[r] at the same edge the write is registered.
  - Same edge, same register for set and clear: set wins (newer instruction still in flight).
  - Set and clear on different registers on the same edge both take effect.
  - Clearing a non-pending register is harmless.
- Reset mid-operation:
  - Any unconsumed request is dropped; wb_en=0 next cycle; pending cleared.
  - No write is issued for a grant coincident with reset.
- Data width: rd and data pass through unmodified; no arithmetic.

Test Plan:
- Reset then idle:
  - Stimulus: reset high 2 cycles, then all valids 0 for 5 cycles.
  - Required: wb_en=0, pending=0, both ready=0 throughout.
- Single ALU write:
  - Stimulus: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle.
  - Required: alu_ready=1 that cycle; next cycle wb_en=1, wb_ptr=5, wb_data=0xDEADBEEF; following cycle wb_en=0.
- Contention round-robin:
  - Stimulus: both valid continuously for 4 cycles (alu rd=1/data=0x11, lsu rd=2/data=0x22) after reset.
  - Required: grants ALU, LSU, ALU, LSU; wb_ptr sequence 1,2,1,2 with wb_en=1 each cycle.
- x0 write:
  - Stimulus: lsu_valid=1, lsu_rd=0, lsu_data=0xFFFFFFFF.
  - Required: lsu_ready=1; next cycle wb_en=0; pending unchanged.
- Scoreboard set/clear collision:
  - Stimulus: issue_valid rd=7; two cycles later, in the same cycle, ALU grant for rd=7 and issue_valid rd=7.
  - Required: pending[7]=1 after the first issue and stays 1 after the collision; a later lone grant for rd=7 clears it to 0.
- Reset mid-transfer:
  - Stimulus: alu_valid=1, rd=3, with pending[3]=1; assert reset that cycle.
  - Required: alu_ready=0; next cycle wb_en=0, pending=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and LSU
// writeback, plus a pending-write scoreboard for RAW hazard detection.
module regfile_write_arbiter #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [$clog2(NREG)-1:0]  alu_rd,
   input  logic [XLEN-1:0]          alu_data,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [$clog2(NREG)-1:0]  lsu_rd,
   input  logic [XLEN-1:0]          lsu_data,
   input  logic                     issue_valid,
   input  logic [$clog2(NREG)-1:0]  issue_rd,
   output logic                     wb_en,
   output logic [$clog2(NREG)-1:0]  wb_ptr,
   output logic [XLEN-1:0]          wb_data,
   output logic [NREG-1:0]          pending
);

   localparam int RW = $clog2(NREG);

   logic             r_last_lsu;
   logic             r_wb_en;
   logic [RW-1:0]    r_wb_ptr;
   logic [XLEN-1:0]  r_wb_data;
   logic [NREG-1:0]  r_pending;

   logic             w_gnt_alu;
   logic             w_gnt_lsu;
   logic             w_gnt;
   logic [RW-1:0]    w_rd;
   logic [XLEN-1:0]  w_data;
   logic [NREG-1:0]  w_pend_nxt;

   // Under contention the source that did not win last time goes first.
   assign w_gnt_alu = !reset && alu_valid && (!lsu_valid || r_last_lsu);
   assign w_gnt_lsu = !reset && lsu_valid && (!alu_valid || !r_last_lsu);
   assign w_gnt     = w_gnt_alu || w_gnt_lsu;
   assign w_rd      = w_gnt_lsu ? lsu_rd : alu_rd;
   assign w_data    = w_gnt_lsu ? lsu_data : alu_data;

   // Set is applied after clear so a re-issued destination stays pending.
   always_comb begin
      w_pend_nxt = r_pending;
      if (w_gnt) begin
         w_pend_nxt[w_rd] = 1'b0;
      end
      if (issue_valid) begin
         w_pend_nxt[issue_rd] = 1'b1;
      end
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_lsu <= 1'b1;
         r_wb_en    <= 1'b0;
         r_wb_ptr   <= '0;
         r_wb_data  <= '0;
         r_pending  <= '0;
      end else begin
         r_wb_en   <= w_gnt && (w_rd != '0);
         r_pending <= w_pend_nxt;
         if (w_gnt) begin
            r_last_lsu <= w_gnt_lsu;
            r_wb_ptr   <= w_rd;
            r_wb_data  <= w_data;
         end
      end
   end

   assign alu_ready = w_gnt_alu;
   assign lsu_ready = w_gnt_lsu;
   assign wb_en     = r_wb_en;
   assign wb_ptr    = r_wb_ptr;
   assign wb_data   = r_wb_data;
   assign pending   = r_pending;

endmodule
